pool_requant_unit: RTL and testbench
====================================

// Module: pool_requant_unit
// PURPOSE
//   Downstream stage of the 1-D convolution engine. Captures the 30 signed 18-bit conv results
//   on the engine's one-cycle done pulse, then applies 2:1 max-pool and ReLU. Each pooled value
//   is arithmetically right-shifted and saturated to int8. The 15 outputs stream out over a
//   valid/ready interface to the next layer's row buffer.
// PARAMETERS
//   N_IN   30  conv results per row (even, >=2)
//   IN_W   18  signed input width
//   OUT_W  8   signed output width
//   SHIFT  4   requantisation right-shift (0..IN_W-1)
// PORTS
//   clk        in   1              single clock, all logic on posedge
//   rst_n      in   1              asynchronous, active-low reset
//   in_valid   in   1              one-cycle pulse: in_data valid (conv done_signal)
//   in_data    in   IN_W x N_IN    signed unpacked array [0:N_IN-1], conv result_data
//   out_valid  out  1              out_data/out_last valid
//   out_ready  in   1              consumer accepts beat when out_valid && out_ready
//   out_data   out  OUT_W          signed pooled/requantised value, range 0..2^(OUT_W-1)-1
//   out_last   out  1              high on the final (N_IN/2-1) beat
//   busy       out  1              high while state != IDLE
//   row_done   out  1              one-cycle pulse after last beat accepted
//   overrun    out  1              sticky: an in_valid pulse was dropped
// BEHAVIOUR
//   - Reset (async assert, sync release): state=IDLE, k=0, buffer cleared, all outputs 0.
//   - FSM IDLE -> STREAM -> IDLE. In IDLE, in_valid captures all N_IN inputs into buf, sets k=0,
//     and enters STREAM.
//   - Latency: in_valid sampled at edge N; out_valid=1 with beat 0 from edge N (cycle N+1).
//   - STREAM: out_valid=1; beat k uses p = max(buf[2k], buf[2k+1]) (signed compare).
//     r = (p<0) ? 0 : p; q = r >>> SHIFT (truncate); out_data = (q > 2^(OUT_W-1)-1) ? 127 : q.
//   - out_data, out_last are combinational from registered buf/k; 0 when out_valid=0.
//   - out_data and out_last stay stable while out_valid && !out_ready. No beat is skipped or
//     repeated.
//   - Accept (out_valid && out_ready): k++. On accept with k==N_IN/2-1 (out_last=1): row_done
//     pulses next cycle and state returns to IDLE.
//   - Simultaneous last-beat accept and in_valid: the new row is captured, k=0, and the FSM
//     stays in STREAM. row_done still pulses; no bubble; overrun is not set.
//   - in_valid in STREAM at any other time: pulse dropped, overrun<=1, current stream unaffected.
//     overrun clears only on reset.
//   - in_valid in IDLE while out_ready toggles: no effect on capture.
//   - Reset mid-stream: outputs drop to 0 asynchronously; the partial row is discarded.
//   - k width is $clog2(N_IN/2). Pooling and compares use IN_W signed; the shift is done on a
//     non-negative value.
// STRUCTURE
//   - npu_pkg: typedef enum logic {IDLE, STREAM} pr_state_t.
//   - npu_pkg: localparams CONV_N=30, CONV_W=18, ACT_W=8.
//   - npu_pkg: function sat_u(): saturate a non-negative value to the signed max.
//   - Sub-module requant_sat (combinational): signed IN_W pair -> max, ReLU, shift, saturate
//     -> OUT_W. One instance fed by buf[2k], buf[2k+1].
//   - Top holds the FSM, the N_IN x IN_W capture buffer, k, and the overrun/row_done flops.
// TESTING
//   1. All in_data=1000, out_ready=1 -> 15 beats of 62 on consecutive cycles.
//      out_last on beat 14; row_done 1 cycle later; busy low after.
//   2. Pairs (-5,-3)->0, (-7,16)->1, (3000,10)->127 (sat), (15,16)->1, (-131072,131071)->127.
//   3. Backpressure: out_ready=0 for 3 cycles at beat 5 -> out_data/out_valid held constant.
//      Beat 5 is emitted once; 15 beats total.
//   4. in_valid at beat 7 with different data -> overrun=1 and stays 1.
//      Remaining beats come from the first row; no second stream follows.
//   5. in_valid coincident with the accepted beat 14 -> second row's beat 0 on the next cycle.
//      out_valid never drops; overrun stays 0.
//   6. rst_n low mid-stream at beat 9 -> out_valid=0 immediately, busy=0.
//      After release, a new in_valid streams from beat 0.

Source files
------------

// File: rtl/npu_pkg.sv
// npu_pkg: shared types, sizes and helpers for the NPU post-processing stages
package npu_pkg;

    typedef enum logic {IDLE, STREAM} pr_state_t;

    localparam int CONV_N = 30;
    localparam int CONV_W = 18;
    localparam int ACT_W  = 8;

    // Clamp a non-negative value to the largest positive value of a w-bit signed word
    function automatic int sat_u(input int v, input int w);
        int lim;
        lim = (1 << (w - 1)) - 1;
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/requant_sat.sv
// requant_sat: pair max-pool, ReLU, arithmetic right-shift and int8 saturation
module requant_sat
    import npu_pkg::*;
#(
    parameter int IN_W  = CONV_W,
    parameter int OUT_W = ACT_W,
    parameter int SHIFT = 4
) (
    input  logic signed [IN_W-1:0]  a,
    input  logic signed [IN_W-1:0]  b,
    output logic signed [OUT_W-1:0] y
);

    logic signed [IN_W-1:0] p;
    logic signed [IN_W-1:0] r;
    logic signed [IN_W-1:0] q;

    // Pool the pair, clip negatives, then shift the non-negative result and clamp it
    always_comb begin
        p = (a > b) ? a : b;
        r = p[IN_W-1] ? '0 : p;
        q = r >>> SHIFT;
        y = OUT_W'(sat_u(int'(q), OUT_W));
    end

endmodule

// File: rtl/pool_requant_unit.sv
// pool_requant_unit: captures a conv row, streams 2:1 max-pooled requantised int8 beats
module pool_requant_unit
    import npu_pkg::*;
#(
    parameter int N_IN  = CONV_N,
    parameter int IN_W  = CONV_W,
    parameter int OUT_W = ACT_W,
    parameter int SHIFT = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic signed [IN_W-1:0]  in_data [0:N_IN-1],
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] out_data,
    output logic                    out_last,
    output logic                    busy,
    output logic                    row_done,
    output logic                    overrun
);

    localparam int N_OUT = N_IN / 2;
    localparam int KW    = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    pr_state_t              state;
    pr_state_t              state_nx;
    logic [KW-1:0]          k;
    logic signed [IN_W-1:0] row_buf [0:N_IN-1];
    logic signed [OUT_W-1:0] pooled;
    logic                   accept;
    logic                   last;
    logic                   capture;

    assign accept  = out_valid && out_ready;
    assign last    = (k == KW'(N_OUT - 1));
    // A new row is taken when idle, or back-to-back as the final beat of the current row leaves
    assign capture = in_valid && (state == IDLE || (accept && last));

    requant_sat #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .SHIFT (SHIFT)
    ) u_requant_sat (
        .a (row_buf[{k, 1'b0}]),
        .b (row_buf[{k, 1'b1}]),
        .y (pooled)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next state: leave STREAM only when the last beat goes out with no row waiting behind it
    always_comb begin
        state_nx = state;
        if (state == IDLE) state_nx = in_valid ? STREAM : IDLE;
        else               state_nx = (accept && last && !in_valid) ? IDLE : STREAM;
    end

    // Outputs are gated by the streaming state so they read zero when idle
    always_comb begin
        out_valid = (state == STREAM);
        busy      = (state == STREAM);
        out_last  = out_valid && last;
        out_data  = out_valid ? pooled : '0;
    end

    // Row buffer, beat index and status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_buf  <= '{default: '0};
            k        <= '0;
            row_done <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            if (capture) begin
                row_buf <= in_data;
                k       <= '0;
            end else if (accept) begin
                k <= last ? '0 : k + 1'b1;
            end
            row_done <= accept && last;
            overrun  <= overrun | (in_valid && !capture);
        end
    end

endmodule

// File: tb/tb_pool_requant_unit.sv
// tb_pool_requant_unit: directed stimulus with a queue scoreboard and a negedge monitor
module tb_pool_requant_unit;

    localparam int N_IN  = 30;
    localparam int IN_W  = 18;
    localparam int OUT_W = 8;
    localparam int N_OUT = 15;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    in_valid = 1'b0;
    logic                    out_ready = 1'b1;
    logic signed [IN_W-1:0]  in_data [0:N_IN-1];
    logic                    out_valid;
    logic signed [OUT_W-1:0] out_data;
    logic                    out_last;
    logic                    busy;
    logic                    row_done;
    logic                    overrun;

    int errors = 0;
    int checks = 0;
    logic [OUT_W:0] sbq [$];

    pool_requant_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .row_done  (row_done),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int v, input bit l);
        sbq.push_back({l, 8'(v)});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse();
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic fill_const(input int v);
        for (int i = 0; i < N_IN; i++) in_data[i] = IN_W'(v);
    endtask

    // pair j = (16j, 16j+8) pools to 16j+8, which shifts down to j
    task automatic fill_ramp();
        for (int j = 0; j < N_OUT; j++) begin
            in_data[2*j]   = IN_W'(16 * j);
            in_data[2*j+1] = IN_W'(16 * j + 8);
        end
    endtask

    task automatic push_ramp();
        for (int j = 0; j < N_OUT; j++) push(j, j == N_OUT - 1);
    endtask

    task automatic push_const(input int v);
        for (int j = 0; j < N_OUT; j++) push(v, j == N_OUT - 1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sbq.size() != 0 || busy) && n < 200) begin
            step();
            n++;
        end
        chk("drain_timeout", n < 200, 1);
    endtask

    logic           stall = 1'b0;
    logic           exp_rd = 1'b0;
    logic [OUT_W:0] held;
    logic [OUT_W:0] e;

    always @(negedge clk) begin
        if (!rst_n) begin
            stall  = 1'b0;
            exp_rd = 1'b0;
        end else begin
            chk("row_done", row_done, exp_rd);
            if (stall) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_beat", {out_last, out_data}, held);
            end
            exp_rd = out_valid && out_ready && out_last;
            stall  = out_valid && !out_ready;
            held   = {out_last, out_data};
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    chk("extra_beat", out_data, -1);
                end else begin
                    e = sbq.pop_front();
                    chk("beat_data", out_data, e[OUT_W-1:0]);
                    chk("beat_last", out_last, e[OUT_W]);
                end
            end
        end
    end

    int pa [N_OUT] = '{-5, -7, 3000, 15, -131072, 255, 2047, 2032, 2031, 0, 100, -1, 17, 160, 2047};
    int pb [N_OUT] = '{-3, 16, 10, 16, 131071, -1, 2032, 0, 0, 0, 200, -1, -17, 159, 2048};
    int pe [N_OUT] = '{0, 1, 127, 1, 127, 15, 127, 127, 126, 0, 12, 0, 1, 10, 127};

    initial begin
        fill_const(0);
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_data", out_data, 0);
        chk("rst_last", out_last, 0);
        chk("rst_row_done", row_done, 0);
        chk("rst_overrun", overrun, 0);
        step();
        rst_n = 1'b1;
        step();

        // constant row: 1000 >>> 4 = 62 on every beat
        fill_const(1000);
        push_const(62);
        pulse();
        chk("t1_latency_valid", out_valid, 1);
        chk("t1_busy", busy, 1);
        drain();
        chk("t1_busy_after", busy, 0);

        // hand-computed pair table, with out_ready wiggled while idle
        out_ready = 1'b0;
        step();
        out_ready = 1'b1;
        step();
        chk("t2_idle_valid", out_valid, 0);
        for (int j = 0; j < N_OUT; j++) begin
            in_data[2*j]   = IN_W'(pa[j]);
            in_data[2*j+1] = IN_W'(pb[j]);
            push(pe[j], j == N_OUT - 1);
        end
        pulse();
        drain();

        // backpressure for three cycles while beat 5 is presented
        fill_ramp();
        push_ramp();
        pulse();
        repeat (5) step();
        chk("t3_beat5", out_data, 5);
        out_ready = 1'b0;
        repeat (3) step();
        chk("t3_held", out_data, 5);
        out_ready = 1'b1;
        drain();

        // new row arrives exactly as the last beat is accepted
        fill_ramp();
        push_ramp();
        pulse();
        begin
            int n;
            n = 0;
            while (!(out_valid && out_last) && n < 100) begin
                step();
                n++;
            end
            chk("t5_last_timeout", n < 100, 1);
        end
        fill_const(1000);
        push_const(62);
        pulse();
        chk("t5_valid_kept", out_valid, 1);
        chk("t5_beat0", out_data, 62);
        chk("t5_row_done", row_done, 1);
        chk("t5_overrun", overrun, 0);
        drain();
        chk("t5_overrun_end", overrun, 0);

        // pulse during beat 7 is dropped and flagged
        fill_ramp();
        push_ramp();
        pulse();
        repeat (7) step();
        fill_const(320);
        pulse();
        chk("t4_overrun", overrun, 1);
        drain();
        repeat (4) step();
        chk("t4_no_second_row", out_valid, 0);
        chk("t4_overrun_sticky", overrun, 1);

        // reset in the middle of a row
        fill_ramp();
        push_ramp();
        pulse();
        repeat (9) step();
        chk("t6_beat9", out_data, 9);
        rst_n = 1'b0;
        #1;
        chk("t6_valid", out_valid, 0);
        chk("t6_busy", busy, 0);
        chk("t6_data", out_data, 0);
        chk("t6_overrun", overrun, 0);
        sbq.delete();
        step();
        rst_n = 1'b1;
        step();
        fill_ramp();
        push_ramp();
        pulse();
        chk("t6_restart_beat0", out_data, 0);
        drain();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
